sixteenbit_dmem_resp: RTL and testbench

SIXTEENBIT_DMEM_RESP -- requirements
Module: sixteenbit_dmem_resp

---
 rtl/sixteenbit_pkg.sv | 13 +
 rtl/sixteenbit_agu.sv | 20 ++
 rtl/sixteenbit_dmem_resp.sv | 108 ++++++++++
 tb/tb_sixteenbit_dmem_resp.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sixteenbit_pkg.sv
// Shared types and constants for the 16-bit data memory response block.
// Holds the controller state encoding and the default memory depth.
package sixteenbit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_state_t;

  localparam int DMEM_DEPTH_DEFAULT = 256;

endpackage

// File: rtl/sixteenbit_agu.sv
// Address generator: ea = base + sign-extended offset (mod 2^16), plus range check.
// Purely combinational, zero latency, no backpressure.
module sixteenbit_agu
  import sixteenbit_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH_DEFAULT
) (
  input  logic [15:0] base,
  input  logic [7:0]  offset,
  output logic [15:0] ea,
  output logic        in_range
);

  localparam logic [16:0] LIMIT = 17'(DEPTH);

  // 16-bit sum drops the carry, giving the required wrap-around
  assign ea       = base + {{8{offset[7]}}, offset};
  assign in_range = ({1'b0, ea} < LIMIT);

endmodule

// File: rtl/sixteenbit_dmem_resp.sv
// Single-outstanding data memory: one request in IDLE, READ_LAT ACCESS cycles, then RESP.
// Response held in RESP until resp_ready; req_ready is low outside IDLE.
module sixteenbit_dmem_resp
  import sixteenbit_pkg::*;
#(
  parameter int DEPTH    = DMEM_DEPTH_DEFAULT,
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] base,
  input  logic [7:0]  offset,
  input  logic [15:0] wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] rdata,
  output logic        resp_err
);

  localparam int         AW   = $clog2(DEPTH);
  localparam logic [2:0] LAST = 3'(READ_LAT - 1);

  dmem_state_t state, state_nxt;
  logic [2:0]  lat_cnt;
  logic        accept;
  logic        last_access;
  logic [15:0] ea;
  logic        in_range;
  logic        cap_we;
  logic        cap_in_range;
  logic [15:0] cap_wdata;
  logic [AW-1:0] cap_addr;
  logic [15:0] mem [DEPTH];
  logic        unused_ea_hi;

  sixteenbit_agu #(.DEPTH(DEPTH)) u_agu (
    .base     (base),
    .offset   (offset),
    .ea       (ea),
    .in_range (in_range)
  );

  // High address bits only matter for the range check inside the AGU
  assign unused_ea_hi = ^ea[15:AW];

  assign accept      = req_valid && req_ready;
  assign last_access = (state == ACCESS) && (lat_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = ACCESS;
      ACCESS:  if (last_access) state_nxt = RESP;
      RESP:    if (resp_ready)  state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt      <= 3'd0;
      cap_we       <= 1'b0;
      cap_in_range <= 1'b0;
      cap_wdata    <= 16'h0000;
      cap_addr     <= '0;
      rdata        <= 16'h0000;
      resp_err     <= 1'b0;
    end else begin
      if (accept) begin
        cap_we       <= req_we;
        cap_wdata    <= wdata;
        cap_addr     <= ea[AW-1:0];
        cap_in_range <= in_range;
        lat_cnt      <= 3'd0;
      end
      if (state == ACCESS) begin
        lat_cnt <= last_access ? 3'd0 : lat_cnt + 3'd1;
      end
      if (last_access) begin
        rdata    <= (!cap_we && cap_in_range) ? mem[cap_addr] : 16'h0000;
        resp_err <= !cap_in_range;
      end
      if (resp_valid && resp_ready) begin
        rdata    <= 16'h0000;
        resp_err <= 1'b0;
      end
    end
  end

  // Write only on the final ACCESS edge; a reset before it leaves state != ACCESS
  always_ff @(posedge clk) begin
    if (last_access && cap_we && cap_in_range) mem[cap_addr] <= cap_wdata;
  end

endmodule

// File: tb/tb_sixteenbit_dmem_resp.sv
// Scoreboard bench for sixteenbit_dmem_resp: expected responses are queued at
// request time from a reference memory model and popped when the DUT responds.
module tb_sixteenbit_dmem_resp;

  localparam int DEPTH    = 256;
  localparam int READ_LAT = 2;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] base = 16'h0000;
  logic [7:0]  offset = 8'h00;
  logic [15:0] wdata = 16'h0000;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [15:0] rdata;
  logic        resp_err;

  exp_t        sb[$];
  logic [15:0] mdl [DEPTH];
  int          n_chk  = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  sixteenbit_dmem_resp #(.DEPTH(DEPTH), .READ_LAT(READ_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .base       (base),
    .offset     (offset),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .rdata      (rdata),
    .resp_err   (resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One full transaction; hold = cycles resp_ready stays low after resp_valid.
  task automatic txn(input string tag, input logic we, input logic [15:0] b,
                     input logic [7:0] off, input logic [15:0] wd, input int hold);
    exp_t        e;
    logic [15:0] ea;
    int          k;
    @(negedge clk);
    chk({tag, "_req_ready"}, req_ready, 1);
    req_valid  = 1'b1;
    req_we     = we;
    base       = b;
    offset     = off;
    wdata      = wd;
    resp_ready = (hold == 0);
    ea = b + {{8{off[7]}}, off};
    if (ea < 16'(DEPTH)) begin
      e.err = 1'b0;
      if (we) begin
        e.rdata = 16'h0000;
        mdl[ea[7:0]] = wd;
      end else begin
        e.rdata = mdl[ea[7:0]];
      end
    end else begin
      e.rdata = 16'h0000;
      e.err   = 1'b1;
    end
    sb.push_back(e);
    @(posedge clk);
    k = 1;
    @(negedge clk);
    // junk store held on the request port while busy must be ignored
    req_we = 1'b1; base = 16'd62; offset = 8'h00; wdata = 16'hDEAD;
    while (!resp_valid && k < 20) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, k, READ_LAT + 1);
    chk({tag, "_resp_valid"}, resp_valid, 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, rdata, e.rdata);
      chk({tag, "_err"}, resp_err, e.err);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_hold_valid"}, resp_valid, 1);
        chk({tag, "_hold_rdata"}, rdata, e.rdata);
        chk({tag, "_hold_err"}, resp_err, e.err);
        chk({tag, "_hold_req_ready"}, req_ready, 0);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_post_valid"}, resp_valid, 0);
    chk({tag, "_post_idle"}, req_ready, 1);
  endtask

  initial begin
    int seen;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_err", resp_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    txn("seed62",  1'b1, 16'd60,    8'd2,   16'h6262, 0);
    txn("st20p2",  1'b1, 16'd20,    8'd2,   16'h1234, 0);
    txn("ld22",    1'b0, 16'd22,    8'd0,   16'h0000, 0);
    txn("st10m2",  1'b1, 16'd10,    8'hFE,  16'h5678, 0);
    txn("ld8",     1'b0, 16'd8,     8'd0,   16'h0000, 0);
    txn("ld_oor",  1'b0, 16'd12345, 8'd5,   16'h0000, 0);
    txn("st_oor",  1'b1, 16'd12345, 8'd5,   16'h9999, 0);
    txn("ld62",    1'b0, 16'd62,    8'd0,   16'h0000, 0);
    txn("st_wrap", 1'b1, 16'hFFFF,  8'd1,   16'hBEEF, 0);
    txn("ld0",     1'b0, 16'd0,     8'd0,   16'h0000, 0);
    txn("ld22_bp", 1'b0, 16'd22,    8'd0,   16'h0000, 5);
    txn("ld_neg",  1'b0, 16'd0,     8'h80,  16'h0000, 0);
    txn("st255",   1'b1, 16'h0100,  8'hFF,  16'h00FF, 0);
    txn("ld255",   1'b0, 16'd255,   8'd0,   16'h0000, 2);
    txn("seed4",   1'b1, 16'd4,     8'd0,   16'h1111, 0);

    // store aborted by reset during ACCESS: no write, no response
    @(negedge clk);
    chk("abort_req_ready", req_ready, 1);
    req_valid = 1'b1; req_we = 1'b1; base = 16'd4; offset = 8'd0; wdata = 16'hAAAA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_req_ready_now", req_ready, 1);
    chk("abort_resp_valid_now", resp_valid, 0);
    chk("abort_rdata_now", rdata, 16'h0000);
    chk("abort_err_now", resp_err, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < READ_LAT + 3; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("abort_no_resp", seen, 0);
    txn("ld4", 1'b0, 16'd4, 8'd0, 16'h0000, 0);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
